mpu_bus_ctrl: RTL and testbench

Bus controller that sits directly downstream of `mpu`. It consumes the MPU's `ABH`/`ABL`/`R_W`/`DB_OUT` bus cycles and produces `DB_IN` and `RDY` for it. Each cycle is decoded into one of three regions:
- a synchronous RAM with one-cycle read latency;
- a handshaked I/O page;
- unmapped space.

The controller stalls the MPU through `RDY` until each access completes. It replaces the combinational `memory` model in system builds.

---
 rtl/mpu_bus_pkg.sv | 19 +
 rtl/mpu_bus_decode.sv | 23 ++
 rtl/mpu_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mpu_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_bus_pkg.sv
// Shared types and defaults for the MPU bus controller.
package mpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        IO_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_t;

    localparam logic [7:0] UNMAPPED_VAL_DEF = 8'hFF;

endpackage

// File: rtl/mpu_bus_decode.sv
// Combinational address decode: I/O page first, then RAM, else unmapped.
module mpu_bus_decode
    import mpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW  = 15,
    parameter logic [7:0]  IO_PAGE = 8'hD0
) (
    input  logic [15:0] addr,
    output region_t     region
);

    localparam int unsigned RAM_SIZE = 32'd1 << RAM_AW;

    always_comb begin
        region = REG_NONE;
        if (addr[15:8] == IO_PAGE) begin
            region = REG_IO;
        end else if (32'(addr) < RAM_SIZE) begin
            region = REG_RAM;
        end
    end

endmodule

// File: rtl/mpu_bus_ctrl.sv
// Bus controller between the MPU and a synchronous RAM / handshaked I/O page.
// Stalls the MPU via RDY until each access completes.
module mpu_bus_ctrl
    import mpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW       = 15,
    parameter logic [7:0]  IO_PAGE      = 8'hD0,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  UNMAPPED_VAL = UNMAPPED_VAL_DEF
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic [7:0]        ABH,
    input  logic [7:0]        ABL,
    input  logic              R_W,
    input  logic [7:0]        DB_OUT,
    output logic [7:0]        DB_IN,
    output logic              RDY,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [7:0]        RAM_WDATA,
    input  logic [7:0]        RAM_RDATA,
    output logic              IO_REQ,
    output logic              IO_WE,
    output logic [7:0]        IO_ADDR,
    output logic [7:0]        IO_WDATA,
    input  logic [7:0]        IO_RDATA,
    input  logic              IO_ACK,
    output logic              BUS_ERR
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    region_t          region;
    logic [15:0]      addr;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic             io_req_q;
    logic             io_start;
    logic             io_ack_done;
    logic             io_timeout;

    assign addr      = {ABH, ABL};
    assign RAM_ADDR  = addr[RAM_AW-1:0];
    assign RAM_WDATA = DB_OUT;
    assign IO_REQ    = io_req_q;
    assign BUS_ERR   = (state_q == DONE) && err_q && !RES;

    mpu_bus_decode #(
        .RAM_AW  (RAM_AW),
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .addr   (addr),
        .region (region)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and MPU/RAM strobes; reset overrides everything visible.
    always_comb begin
        state_d     = state_q;
        RDY         = 1'b0;
        DB_IN       = UNMAPPED_VAL;
        RAM_EN      = 1'b0;
        RAM_WE      = 1'b0;
        io_start    = 1'b0;
        io_ack_done = 1'b0;
        io_timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                case (region)
                    REG_RAM: begin
                        if (R_W) begin
                            RAM_EN  = 1'b1;
                            state_d = RAM_RD;
                        end else begin
                            RAM_WE = 1'b1;
                            RDY    = 1'b1;
                        end
                    end
                    REG_IO: begin
                        io_start = 1'b1;
                        state_d  = IO_WAIT;
                    end
                    default: RDY = 1'b1;
                endcase
            end
            RAM_RD: begin
                DB_IN   = RAM_RDATA;
                RDY     = 1'b1;
                state_d = IDLE;
            end
            IO_WAIT: begin
                // ACK takes precedence over a coincident timeout.
                if (IO_ACK) begin
                    io_ack_done = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    io_timeout = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                DB_IN   = rdata_q;
                RDY     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (RES) begin
            state_d     = IDLE;
            RDY         = 1'b0;
            DB_IN       = UNMAPPED_VAL;
            RAM_EN      = 1'b0;
            RAM_WE      = 1'b0;
            io_start    = 1'b0;
            io_ack_done = 1'b0;
            io_timeout  = 1'b0;
        end
    end

    // I/O request, latched fields, wait counter and completion data.
    always_ff @(posedge CLK) begin
        if (RES) begin
            io_req_q <= 1'b0;
            IO_ADDR  <= 8'h00;
            IO_WE    <= 1'b0;
            IO_WDATA <= 8'h00;
            cnt_q    <= '0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            io_req_q <= (state_d == IO_WAIT);
            if (io_start) begin
                IO_ADDR  <= ABL;
                IO_WE    <= ~R_W;
                IO_WDATA <= DB_OUT;
                cnt_q    <= '0;
            end else if (state_q == IO_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (io_ack_done) begin
                rdata_q <= IO_RDATA;
            end else if (io_timeout) begin
                rdata_q <= UNMAPPED_VAL;
                err_q   <= 1'b1;
            end
            if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mpu_bus_ctrl.sv
// Self-checking bench for mpu_bus_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_mpu_bus_ctrl;

    logic        CLK;
    logic        RES;
    logic [7:0]  ABH, ABL, DB_OUT, DB_IN;
    logic        R_W, RDY;
    logic [14:0] RAM_ADDR;
    logic        RAM_EN, RAM_WE;
    logic [7:0]  RAM_WDATA, RAM_RDATA;
    logic        IO_REQ, IO_WE, IO_ACK, BUS_ERR;
    logic [7:0]  IO_ADDR, IO_WDATA, IO_RDATA;

    int total = 0;
    int bad   = 0;

    // observations of the last access
    int          cyc, nerr, nreq, nwe, nen;
    logic [7:0]  dat, s_ioaddr, s_iowdata;
    logic        s_iowe;
    logic [14:0] s_ramaddr;

    // behavioural synchronous RAM attached to the controller
    logic [7:0] ram [0:32767];
    always @(posedge CLK) begin
        if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
        if (RAM_EN) RAM_RDATA <= ram[RAM_ADDR];
    end

    // reference contents of RAM as seen by the MPU
    logic [7:0]  ref_mem [int];
    logic [15:0] written_q [$];

    mpu_bus_ctrl dut (
        .CLK(CLK), .RES(RES), .ABH(ABH), .ABL(ABL), .R_W(R_W), .DB_OUT(DB_OUT),
        .DB_IN(DB_IN), .RDY(RDY), .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .IO_REQ(IO_REQ), .IO_WE(IO_WE),
        .IO_ADDR(IO_ADDR), .IO_WDATA(IO_WDATA), .IO_RDATA(IO_RDATA), .IO_ACK(IO_ACK),
        .BUS_ERR(BUS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 0 = RAM, 1 = IO, 2 = unmapped
    function automatic int region_of(input logic [15:0] a);
        if (a[15:8] == 8'hD0) return 1;
        if (a < 16'h8000) return 0;
        return 2;
    endfunction

    // Acts as the MPU (holds the bus until RDY) and as the I/O device (ACK in request cycle ack_k).
    task automatic run_access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                              input int ack_k, input logic [7:0] iod);
        int  reqn;
        bit  done;
        @(negedge CLK);
        ABH = a[15:8]; ABL = a[7:0]; R_W = rw; DB_OUT = wd; IO_RDATA = iod;
        cyc = 0; nerr = 0; nwe = 0; nen = 0; reqn = 0; done = 0; dat = 8'h00;
        s_ioaddr = 8'h00; s_iowdata = 8'h00; s_iowe = 1'b0; s_ramaddr = 15'h0;
        while (!done && cyc < 64) begin
            #1;
            cyc++;
            if (BUS_ERR) nerr++;
            if (RAM_WE) nwe++;
            if (RAM_EN) nen++;
            if (RAM_WE || RAM_EN) s_ramaddr = RAM_ADDR;
            if (IO_REQ) begin
                reqn++;
                if (reqn == 1) begin
                    s_ioaddr = IO_ADDR; s_iowe = IO_WE; s_iowdata = IO_WDATA;
                end
            end
            IO_ACK = IO_REQ && (reqn == ack_k);
            if (RDY) begin
                done = 1;
                dat  = DB_IN;
            end else begin
                @(negedge CLK);
            end
        end
        IO_ACK = 1'b0;
        nreq = reqn;
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        RES = 1'b1; ABH = 8'h01; ABL = 8'h23; R_W = 1'b1; DB_OUT = 8'h00;
        IO_ACK = 1'b0; IO_RDATA = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        total++; if (RDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", RDY); end
        total++; if (DB_IN !== 8'hFF) begin bad++; $display("FAIL reset_db_in: got %h want ff", DB_IN); end
        total++; if (RAM_EN !== 1'b0 || RAM_WE !== 1'b0) begin bad++; $display("FAIL reset_ram_strobe: got en=%b we=%b want 0/0", RAM_EN, RAM_WE); end
        total++; if (IO_REQ !== 1'b0 || BUS_ERR !== 1'b0) begin bad++; $display("FAIL reset_io: got req=%b err=%b want 0/0", IO_REQ, BUS_ERR); end
        total++; if ({IO_ADDR, IO_WDATA, IO_WE} !== 17'h0) begin bad++; $display("FAIL reset_io_regs: got addr=%h wdata=%h we=%b want 0", IO_ADDR, IO_WDATA, IO_WE); end
        @(negedge CLK);
        ABH = 8'h90; ABL = 8'h00; RES = 1'b0;
    endtask

    task automatic test_ram_write_read();
        run_access(16'h0123, 1'b0, 8'h5A, 0, 8'h00);
        ref_mem[32'h0123] = 8'h5A; written_q.push_back(16'h0123);
        total++; if (cyc !== 1 || nwe !== 1 || nen !== 0) begin bad++; $display("FAIL ram_write: got cyc=%0d we=%0d en=%0d want 1/1/0", cyc, nwe, nen); end
        total++; if (s_ramaddr !== 15'h0123) begin bad++; $display("FAIL ram_write_addr: got %h want 0123", s_ramaddr); end
        run_access(16'h0123, 1'b1, 8'h00, 0, 8'h00);
        total++; if (cyc !== 2 || nen !== 1) begin bad++; $display("FAIL ram_read_timing: got cyc=%0d en=%0d want 2/1", cyc, nen); end
        total++; if (dat !== 8'h5A) begin bad++; $display("FAIL ram_read_data: got %h want 5a", dat); end
    endtask

    task automatic test_io_read();
        run_access(16'hD010, 1'b1, 8'h00, 3, 8'h3C);
        total++; if (cyc !== 5 || nreq !== 3) begin bad++; $display("FAIL io_read_timing: got cyc=%0d req=%0d want 5/3", cyc, nreq); end
        total++; if (dat !== 8'h3C || nerr !== 0) begin bad++; $display("FAIL io_read_data: got %h err=%0d want 3c/0", dat, nerr); end
        total++; if (s_ioaddr !== 8'h10 || s_iowe !== 1'b0) begin bad++; $display("FAIL io_read_fields: got addr=%h we=%b want 10/0", s_ioaddr, s_iowe); end
    endtask

    task automatic test_io_write();
        run_access(16'hD0FF, 1'b0, 8'h77, 1, 8'h00);
        total++; if (cyc !== 3 || nreq !== 1) begin bad++; $display("FAIL io_write_timing: got cyc=%0d req=%0d want 3/1", cyc, nreq); end
        total++; if (s_iowe !== 1'b1 || s_iowdata !== 8'h77 || s_ioaddr !== 8'hFF) begin bad++; $display("FAIL io_write_fields: got we=%b wdata=%h addr=%h want 1/77/ff", s_iowe, s_iowdata, s_ioaddr); end
    endtask

    task automatic test_io_timeout();
        run_access(16'hD042, 1'b1, 8'h00, 0, 8'hAB);
        total++; if (cyc !== 18 || nreq !== 16) begin bad++; $display("FAIL io_timeout_timing: got cyc=%0d req=%0d want 18/16", cyc, nreq); end
        total++; if (dat !== 8'hFF || nerr !== 1) begin bad++; $display("FAIL io_timeout_result: got %h err=%0d want ff/1", dat, nerr); end
        // ACK in the very last allowed cycle beats the timeout
        run_access(16'hD043, 1'b1, 8'h00, 16, 8'h5C);
        total++; if (cyc !== 18 || dat !== 8'h5C || nerr !== 0) begin bad++; $display("FAIL io_ack_at_limit: got cyc=%0d data=%h err=%0d want 18/5c/0", cyc, dat, nerr); end
    endtask

    task automatic test_unmapped();
        run_access(16'h1000, 1'b0, 8'h11, 0, 8'h00);
        ref_mem[32'h1000] = 8'h11; written_q.push_back(16'h1000);
        run_access(16'h9000, 1'b1, 8'h00, 0, 8'h00);
        total++; if (cyc !== 1 || dat !== 8'hFF) begin bad++; $display("FAIL unmapped_read: got cyc=%0d data=%h want 1/ff", cyc, dat); end
        total++; if (nen !== 0 || nwe !== 0 || nreq !== 0) begin bad++; $display("FAIL unmapped_strobes: got en=%0d we=%0d req=%0d want 0", nen, nwe, nreq); end
        run_access(16'h9000, 1'b0, 8'hEE, 0, 8'h00);
        total++; if (cyc !== 1 || nwe !== 0) begin bad++; $display("FAIL unmapped_write: got cyc=%0d we=%0d want 1/0", cyc, nwe); end
        run_access(16'h1000, 1'b1, 8'h00, 0, 8'h00);
        total++; if (dat !== 8'h11) begin bad++; $display("FAIL unmapped_alias: got %h want 11", dat); end
    endtask

    task automatic test_reset_mid_io();
        int errs;
        int reqs;
        int rdys;
        @(negedge CLK);
        ABH = 8'hD0; ABL = 8'h20; R_W = 1'b1; IO_ACK = 1'b0;
        @(negedge CLK); #1;
        total++; if (IO_REQ !== 1'b1) begin bad++; $display("FAIL mid_io_req_before: got %b want 1", IO_REQ); end
        @(negedge CLK);
        RES = 1'b1;
        #1;
        total++; if (RDY !== 1'b0 || BUS_ERR !== 1'b0) begin bad++; $display("FAIL mid_io_res_first: got rdy=%b err=%b want 0/0", RDY, BUS_ERR); end
        errs = 0; reqs = 0; rdys = 0;
        repeat (20) begin
            @(negedge CLK); #1;
            if (BUS_ERR) errs++;
            if (IO_REQ) reqs++;
            if (RDY) rdys++;
        end
        total++; if (reqs !== 0) begin bad++; $display("FAIL mid_io_req_drop: got %0d req cycles want 0", reqs); end
        total++; if (rdys !== 0 || errs !== 0) begin bad++; $display("FAIL mid_io_hold: got rdy=%0d err=%0d cycles want 0/0", rdys, errs); end
        @(negedge CLK);
        ABH = 8'h90; ABL = 8'h00; RES = 1'b0;
        #1;
        total++; if (RDY !== 1'b1 || BUS_ERR !== 1'b0) begin bad++; $display("FAIL mid_io_release: got rdy=%b err=%b want 1/0", RDY, BUS_ERR); end
        run_access(16'h0123, 1'b1, 8'h00, 0, 8'h00);
        total++; if (cyc !== 2 || dat !== 8'h5A) begin bad++; $display("FAIL mid_io_ram_after: got cyc=%0d data=%h want 2/5a", cyc, dat); end
    endtask

    // Back-to-back random traffic across all regions.
    task automatic test_random();
        logic [15:0] a;
        logic        rw;
        logic [7:0]  wd, iod, exp_dat;
        int          k, sel, eff, exp_cyc, exp_req, exp_err, exp_we, exp_en;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 3);
            wd  = 8'($urandom);
            iod = 8'($urandom);
            k   = 0;
            case (sel)
                0: begin a = 16'($urandom_range(0, 32767)); rw = 1'b0; end
                1: begin
                    if (written_q.size() == 0) begin
                        a = 16'($urandom_range(0, 32767)); rw = 1'b0;
                    end else begin
                        a = written_q[$urandom_range(0, written_q.size() - 1)]; rw = 1'b1;
                    end
                end
                2: begin a = {8'hD0, 8'($urandom)}; rw = 1'($urandom); k = $urandom_range(0, 18); end
                default: begin
                    a = {8'($urandom_range(128, 255)), 8'($urandom)};
                    if (a[15:8] == 8'hD0) a[15:8] = 8'hD1;
                    rw = 1'($urandom);
                end
            endcase
            exp_req = 0; exp_err = 0; exp_we = 0; exp_en = 0; exp_dat = 8'hFF;
            case (region_of(a))
                0: begin
                    if (rw) begin
                        exp_cyc = 2; exp_en = 1; exp_dat = ref_mem[int'(a)];
                    end else begin
                        exp_cyc = 1; exp_we = 1;
                        if (!ref_mem.exists(int'(a))) written_q.push_back(a);
                        ref_mem[int'(a)] = wd;
                    end
                end
                1: begin
                    eff = (k >= 1 && k <= 16) ? k : 0;
                    if (eff != 0) begin
                        exp_cyc = eff + 2; exp_req = eff; exp_dat = iod;
                    end else begin
                        exp_cyc = 18; exp_req = 16; exp_err = 1;
                    end
                end
                default: exp_cyc = 1;
            endcase
            run_access(a, rw, wd, k, iod);
            total++; if (cyc !== exp_cyc) begin bad++; $display("FAIL rand_cycles[%0d] a=%h: got %0d want %0d", n, a, cyc, exp_cyc); end
            total++; if (nreq !== exp_req || nerr !== exp_err) begin bad++; $display("FAIL rand_io[%0d] a=%h: got req=%0d err=%0d want %0d/%0d", n, a, nreq, nerr, exp_req, exp_err); end
            total++; if (nwe !== exp_we || nen !== exp_en) begin bad++; $display("FAIL rand_ram[%0d] a=%h: got we=%0d en=%0d want %0d/%0d", n, a, nwe, nen, exp_we, exp_en); end
            if (rw) begin
                total++; if (dat !== exp_dat) begin bad++; $display("FAIL rand_data[%0d] a=%h: got %h want %h", n, a, dat, exp_dat); end
            end
            if (region_of(a) == 1) begin
                total++; if (s_ioaddr !== a[7:0] || s_iowe !== ~rw || s_iowdata !== wd) begin bad++; $display("FAIL rand_fields[%0d]: got addr=%h we=%b wdata=%h want %h/%b/%h", n, s_ioaddr, s_iowe, s_iowdata, a[7:0], ~rw, wd); end
            end else if (exp_we + exp_en > 0) begin
                total++; if (s_ramaddr !== a[14:0]) begin bad++; $display("FAIL rand_ramaddr[%0d]: got %h want %h", n, s_ramaddr, a[14:0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_write_read();
        test_io_read();
        test_io_write();
        test_io_timeout();
        test_unmapped();
        test_reset_mid_io();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
